// File: rtl/noc_pkg.sv
// Shared parameters and packet field helpers for the 4-node linear NoC chain.
package noc_pkg;
    localparam int PACKET_SIZE = 8;
    localparam int NUM_NODES   = 4;
    localparam int ADDR_W      = 2;
    localparam int DEST_LSB    = 0;
    localparam int PAYLOAD_LSB = ADDR_W;

    function automatic logic [ADDR_W-1:0] get_dest(input logic [PACKET_SIZE-1:0] pkt);
        return pkt[DEST_LSB +: ADDR_W];
    endfunction
endpackage

// File: rtl/noc_router.sv
// One router stage: independent one-entry east and west lane registers,
// local ejection on a destination match, otherwise forward one hop per clock.
module noc_router
    import noc_pkg::*;
#(
    parameter int NODE_ID = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   e_in_valid,
    input  logic [PACKET_SIZE-1:0] e_in_data,
    input  logic                   w_in_valid,
    input  logic [PACKET_SIZE-1:0] w_in_data,
    output logic                   e_fwd_valid,
    output logic [PACKET_SIZE-1:0] e_fwd_data,
    output logic                   w_fwd_valid,
    output logic [PACKET_SIZE-1:0] w_fwd_data,
    output logic                   e_eject_valid,
    output logic [PACKET_SIZE-1:0] e_eject_data,
    output logic                   w_eject_valid,
    output logic [PACKET_SIZE-1:0] w_eject_data
);
    // The chain ends have no neighbour in one direction; packets that would
    // leave the chain are simply not forwarded, which discards them.
    localparam logic HAS_EAST = (NODE_ID < NUM_NODES - 1);
    localparam logic HAS_WEST = (NODE_ID > 0);

    logic                   e_valid, w_valid;
    logic [PACKET_SIZE-1:0] e_pkt, w_pkt;
    logic                   e_here, w_here;

    always_ff @(posedge clk) begin
        if (!rst) begin
            e_valid <= 1'b0;
            e_pkt   <= '0;
            w_valid <= 1'b0;
            w_pkt   <= '0;
        end else begin
            if (e_in_valid) begin
                e_valid <= 1'b1;
                e_pkt   <= e_in_data;
            end else begin
                e_valid <= 1'b0;
                e_pkt   <= '0;
            end
            if (w_in_valid) begin
                w_valid <= 1'b1;
                w_pkt   <= w_in_data;
            end else begin
                w_valid <= 1'b0;
                w_pkt   <= '0;
            end
        end
    end

    assign e_here = (get_dest(e_pkt) == ADDR_W'(NODE_ID));
    assign w_here = (get_dest(w_pkt) == ADDR_W'(NODE_ID));

    assign e_eject_valid = e_valid && e_here;
    assign w_eject_valid = w_valid && w_here;
    assign e_eject_data  = e_eject_valid ? e_pkt : '0;
    assign w_eject_data  = w_eject_valid ? w_pkt : '0;

    assign e_fwd_valid = e_valid && !e_here && HAS_EAST;
    assign w_fwd_valid = w_valid && !w_here && HAS_WEST;
    assign e_fwd_data  = e_fwd_valid ? e_pkt : '0;
    assign w_fwd_data  = w_fwd_valid ? w_pkt : '0;
endmodule

// File: rtl/noc_chain4.sv
// Top of the NoC subsystem: four routers in a line, edge injection at nodes
// 0 (eastbound) and 3 (westbound), per-node ejection and a delivery counter.
module noc_chain4
    import noc_pkg::*;
#(
    parameter int PACKET_SIZE = noc_pkg::PACKET_SIZE,
    parameter int NUM_NODES   = noc_pkg::NUM_NODES,
    parameter int ADDR_W      = noc_pkg::ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [PACKET_SIZE-1:0]           left_in,
    input  logic                             left_en,
    input  logic [PACKET_SIZE-1:0]           right_in,
    input  logic                             right_en,
    output logic [NUM_NODES*PACKET_SIZE-1:0] east_data,
    output logic [NUM_NODES-1:0]             east_valid,
    output logic [NUM_NODES*PACKET_SIZE-1:0] west_data,
    output logic [NUM_NODES-1:0]             west_valid,
    output logic [7:0]                       delivered_count
);
    if (ADDR_W != $clog2(NUM_NODES) || PACKET_SIZE != noc_pkg::PACKET_SIZE ||
        NUM_NODES != noc_pkg::NUM_NODES) begin : g_bad_cfg
        $error("noc_chain4: parameters must match noc_pkg");
    end

    logic [NUM_NODES-1:0]                  e_in_valid, w_in_valid;
    logic [NUM_NODES-1:0]                  e_fwd_valid, w_fwd_valid;
    logic [NUM_NODES-1:0][PACKET_SIZE-1:0] e_in_data, w_in_data;
    logic [NUM_NODES-1:0][PACKET_SIZE-1:0] e_fwd_data, w_fwd_data;

    assign e_in_valid[0]           = left_en;
    assign e_in_data[0]            = left_in;
    assign w_in_valid[NUM_NODES-1] = right_en;
    assign w_in_data[NUM_NODES-1]  = right_in;

    for (genvar n = 0; n < NUM_NODES; n++) begin : g_node
        if (n > 0) begin : g_e_link
            assign e_in_valid[n] = e_fwd_valid[n-1];
            assign e_in_data[n]  = e_fwd_data[n-1];
        end
        if (n < NUM_NODES - 1) begin : g_w_link
            assign w_in_valid[n] = w_fwd_valid[n+1];
            assign w_in_data[n]  = w_fwd_data[n+1];
        end

        noc_router #(.NODE_ID(n)) u_router (
            .clk           (clk),
            .rst           (rst),
            .e_in_valid    (e_in_valid[n]),
            .e_in_data     (e_in_data[n]),
            .w_in_valid    (w_in_valid[n]),
            .w_in_data     (w_in_data[n]),
            .e_fwd_valid   (e_fwd_valid[n]),
            .e_fwd_data    (e_fwd_data[n]),
            .w_fwd_valid   (w_fwd_valid[n]),
            .w_fwd_data    (w_fwd_data[n]),
            .e_eject_valid (east_valid[n]),
            .e_eject_data  (east_data[n*PACKET_SIZE +: PACKET_SIZE]),
            .w_eject_valid (west_valid[n]),
            .w_eject_data  (west_data[n*PACKET_SIZE +: PACKET_SIZE])
        );
    end

    // Forwards off either end of the chain go nowhere (always zero by construction).
    logic unused_edge_fwd;
    assign unused_edge_fwd = ^{e_fwd_valid[NUM_NODES-1], e_fwd_data[NUM_NODES-1],
                               w_fwd_valid[0], w_fwd_data[0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            delivered_count <= '0;
        end else begin
            delivered_count <= delivered_count + 8'($countones(east_valid))
                                               + 8'($countones(west_valid));
        end
    end
endmodule

// File: tb/tb_noc_chain4.sv
// Self-checking bench for noc_chain4: latency-based scoreboard plus directed scenario tasks.
module tb_noc_chain4;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  left_in = '0, right_in = '0;
    logic        left_en = 1'b0, right_en = 1'b0;
    logic [31:0] east_data, west_data;
    logic [3:0]  east_valid, west_valid;
    logic [7:0]  delivered_count;

    int checks = 0;
    int passes = 0;

    noc_chain4 dut (
        .clk             (clk),
        .rst             (rst),
        .left_in         (left_in),
        .left_en         (left_en),
        .right_in        (right_in),
        .right_en        (right_en),
        .east_data       (east_data),
        .east_valid      (east_valid),
        .west_data       (west_data),
        .west_valid      (west_valid),
        .delivered_count (delivered_count)
    );

    always #5 clk = ~clk;

    // Scoreboard entry: which lane, ejecting node, packet, edge index after which it shows.
    typedef struct {
        bit         east;
        int         node;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t        sb[$];
    int          edge_idx = 0;
    logic [7:0]  cnt_model = '0;
    logic [3:0]  exp_ev, exp_wv;
    logic [31:0] exp_ed, exp_wd;

    // Scoreboard: push at the injection edge, compare every cycle on the falling edge.
    always begin
        @(posedge clk);
        edge_idx++;
        if (rst !== 1'b1) begin
            sb.delete();
            cnt_model = '0;
        end else begin
            if (left_en === 1'b1)
                sb.push_back('{1'b1, int'(left_in[1:0]), left_in, edge_idx + int'(left_in[1:0])});
            if (right_en === 1'b1)
                sb.push_back('{1'b0, int'(right_in[1:0]), right_in, edge_idx + 3 - int'(right_in[1:0])});
        end
        @(negedge clk);
        exp_ev = '0; exp_wv = '0; exp_ed = '0; exp_wd = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_idx) begin
                if (sb[i].east) begin
                    exp_ev[sb[i].node] = 1'b1;
                    exp_ed[sb[i].node*8 +: 8] = sb[i].data;
                end else begin
                    exp_wv[sb[i].node] = 1'b1;
                    exp_wd[sb[i].node*8 +: 8] = sb[i].data;
                end
                sb.delete(i);
            end
        end
        checks++;
        if (east_valid !== exp_ev) $display("FAIL sb_east_valid edge %0d: got %b want %b", edge_idx, east_valid, exp_ev);
        else passes++;
        checks++;
        if (east_data !== exp_ed) $display("FAIL sb_east_data edge %0d: got %h want %h", edge_idx, east_data, exp_ed);
        else passes++;
        checks++;
        if (west_valid !== exp_wv) $display("FAIL sb_west_valid edge %0d: got %b want %b", edge_idx, west_valid, exp_wv);
        else passes++;
        checks++;
        if (west_data !== exp_wd) $display("FAIL sb_west_data edge %0d: got %h want %h", edge_idx, west_data, exp_wd);
        else passes++;
        checks++;
        if (delivered_count !== cnt_model) $display("FAIL sb_count edge %0d: got %0d want %0d", edge_idx, delivered_count, cnt_model);
        else passes++;
        cnt_model = cnt_model + 8'($countones(exp_ev)) + 8'($countones(exp_wv));
    end

    task automatic do_reset();
        rst = 1'b0; left_en = 1'b0; right_en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        left_en = 1'b1;  left_in = 8'h00;
        right_en = 1'b1; right_in = 8'h03;
        repeat (2) @(negedge clk);
        checks++;
        if ({east_valid, west_valid} !== 8'h00) $display("FAIL reset_valid: got %b want 0", {east_valid, west_valid});
        else passes++;
        checks++;
        if ({east_data, west_data} !== 64'h0) $display("FAIL reset_data: got %h want 0", {east_data, west_data});
        else passes++;
        checks++;
        if (delivered_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", delivered_count);
        else passes++;
        left_en = 1'b0; right_en = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({east_valid, west_valid} !== 8'h00) $display("FAIL reset_release_valid: got %b want 0", {east_valid, west_valid});
        else passes++;
    endtask

    task automatic test_left_far();
        do_reset();
        left_in = 8'b0000_0011; left_en = 1'b1;
        @(negedge clk);
        left_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (east_valid !== 4'b0000) $display("FAIL far_early_valid cyc %0d: got %b want 0000", i, east_valid);
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (east_valid !== 4'b1000) $display("FAIL far_valid: got %b want 1000", east_valid);
        else passes++;
        checks++;
        if (east_data[31:24] !== 8'h03) $display("FAIL far_data: got %h want 03", east_data[31:24]);
        else passes++;
        checks++;
        if (west_valid !== 4'b0000) $display("FAIL far_west_quiet: got %b want 0000", west_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (east_valid !== 4'b0000) $display("FAIL far_one_cycle: got %b want 0000", east_valid);
        else passes++;
        checks++;
        if (delivered_count !== 8'd1) $display("FAIL far_count: got %0d want 1", delivered_count);
        else passes++;
    endtask

    task automatic test_local_eject();
        do_reset();
        left_in = 8'hA4;  left_en = 1'b1;
        right_in = 8'h57; right_en = 1'b1;
        @(negedge clk);
        left_en = 1'b0; right_en = 1'b0;
        checks++;
        if (east_valid !== 4'b0001 || east_data !== 32'h0000_00A4)
            $display("FAIL local_east: got %b/%h want 0001/000000a4", east_valid, east_data);
        else passes++;
        checks++;
        if (west_valid !== 4'b1000 || west_data !== 32'h5700_0000)
            $display("FAIL local_west: got %b/%h want 1000/57000000", west_valid, west_data);
        else passes++;
        @(negedge clk);
        checks++;
        if (delivered_count !== 8'd2) $display("FAIL local_count: got %0d want 2", delivered_count);
        else passes++;
    endtask

    task automatic test_collision();
        do_reset();
        left_in = 8'h12;  left_en = 1'b1;
        right_in = 8'h3E; right_en = 1'b1;
        @(negedge clk);
        left_en = 1'b0; right_en = 1'b0;
        @(negedge clk);
        checks++;
        if (west_valid !== 4'b0100 || west_data !== 32'h003E_0000 || east_valid !== 4'b0000)
            $display("FAIL coll_west: got %b/%h east %b want 0100/003e0000 east 0000", west_valid, west_data, east_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (east_valid !== 4'b0100 || east_data !== 32'h0012_0000 || west_valid !== 4'b0000)
            $display("FAIL coll_east: got %b/%h west %b want 0100/00120000 west 0000", east_valid, east_data, west_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (delivered_count !== 8'd2) $display("FAIL coll_count: got %0d want 2", delivered_count);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] stream [4];
        stream[0] = 8'hF3; stream[1] = 8'hC2; stream[2] = 8'h81; stream[3] = 8'h40;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            left_in = stream[i]; left_en = 1'b1;
            @(negedge clk);
        end
        left_en = 1'b0;
        checks++;
        if (east_valid !== 4'b1111 || east_data !== 32'hF3C2_8140)
            $display("FAIL stream_eject: got %b/%h want 1111/f3c28140", east_valid, east_data);
        else passes++;
        @(negedge clk);
        checks++;
        if (delivered_count !== 8'd4) $display("FAIL stream_count: got %0d want 4", delivered_count);
        else passes++;
    endtask

    task automatic test_midflight_reset();
        do_reset();
        left_in = 8'h03; left_en = 1'b1;
        @(negedge clk);
        left_en = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({east_valid, west_valid} !== 8'h00) $display("FAIL midrst_valid cyc %0d: got %b want 0", i, {east_valid, west_valid});
            else passes++;
            @(negedge clk);
        end
        checks++;
        if (delivered_count !== 8'd0) $display("FAIL midrst_count: got %0d want 0", delivered_count);
        else passes++;
    endtask

    task automatic test_random_traffic();
        int injected = 0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            left_en  = 1'($urandom_range(0, 1));
            right_en = 1'($urandom_range(0, 1));
            left_in  = 8'($urandom);
            right_in = 8'($urandom);
            injected += int'(left_en) + int'(right_en);
            @(negedge clk);
        end
        left_en = 1'b0; right_en = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (delivered_count !== 8'(injected)) $display("FAIL random_count: got %0d want %0d", delivered_count, 8'(injected));
        else passes++;
    endtask

    task automatic test_count_wrap();
        do_reset();
        left_in = 8'h5C; right_in = 8'hA7;
        left_en = 1'b1;  right_en = 1'b1;
        repeat (130) @(negedge clk);
        left_en = 1'b0; right_en = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (delivered_count !== 8'd4) $display("FAIL wrap_count: got %0d want 4", delivered_count);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_left_far();
        test_local_eject();
        test_collision();
        test_back_to_back();
        test_midflight_reset();
        test_random_traffic();
        test_count_wrap();
        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/noc_chain4.md
# noc_chain4

`noc_chain4` is a 4-node, linear, bidirectional network-on-chip fabric. Packets enter at the two edge ports, `left_in` at node 0 and `right_in` at node 3. Each packet travels one hop per clock toward its destination node and is ejected there on a per-node output. It is the top of the NoC subsystem, built from identical router stages in a chain.

## Interface
Parameters:
- `PACKET_SIZE`, default 8: packet width in bits.
- `NUM_NODES`, default 4: number of routers in the chain; fixed at 4 for this block.
- `ADDR_W`, default 2: destination field width, equal to clog2(`NUM_NODES`).

Ports (clock and reset first):
- `clk`  in  1  — the only clock; all state updates on the rising edge.
- `rst`  in  1  — reset, synchronous, active-low.
- `left_in`  in  `PACKET_SIZE`  — packet injected at node 0; travels eastbound.
- `left_en`  in  1  — inject strobe for `left_in`; only 1'b1 injects, and 0, X or Z do not.
- `right_in`  in  `PACKET_SIZE`  — packet injected at node 3; travels westbound.
- `right_en`  in  1  — inject strobe for `right_in`, same rule as `left_en`.
- `east_data`  out  `NUM_NODES*PACKET_SIZE`  — eastbound ejected packet, node n at bits [n*8 +: 8].
- `east_valid`  out  `NUM_NODES`  — bit n high means `east_data` for node n is valid this cycle.
- `west_data`  out  `NUM_NODES*PACKET_SIZE`  — westbound ejected packet, same packing.
- `west_valid`  out  `NUM_NODES`  — bit n high means `west_data` for node n is valid this cycle.
- `delivered_count`  out  8  — total packets ejected since reset, both lanes, wraps modulo 256.

## Operation
- Packet format:
  - bits [`ADDR_W`-1:0] are the destination node id.
  - bits [`PACKET_SIZE`-1:`ADDR_W`] are the payload, which is never modified.
- Each router has two independent one-entry lane registers: eastbound (E) and westbound (W). Each register holds a valid bit and a packet.
- Injection:
  - `left_en`==1 at an edge loads `left_in` into router 0's E register.
  - `right_en`==1 at an edge loads `right_in` into router 3's W register.
  - Both edges may inject in the same cycle.
- Routing in router n, for an occupied lane register:
  - If dest==n, the packet is ejected: the lane's `*_valid[n]` is high and its data is driven combinationally from the register. The packet is then dropped at the next edge.
  - Otherwise, at the next edge it moves to router n+1 (E lane) or router n−1 (W lane).
- Unreachable destinations are discarded without ejection:
  - An E-lane packet at node 3 whose dest is not 3.
  - A W-lane packet at node 0 whose dest is not 0.
  - With a 2-bit destination field this cannot occur for E packets injected at node 0 or W packets injected at node 3, since all ids 0–3 are reachable.
- Lanes never contend: every E register receives only from its west neighbour or from injection, and every W register likewise. No backpressure and no stalls.
- East and west packets may eject at the same node in the same cycle. Both valids go high.
- `delivered_count` adds popcount(`east_valid`) + popcount(`west_valid`) at every edge.
- When a valid bit is low, the corresponding data field is held at 0.

## Timing
- Reset: at an edge with `rst`==0, every valid bit, packet register and `delivered_count` clears to 0. Injection strobes are ignored that cycle.
  - All outputs read 0 after the reset edge.
  - A reset mid-flight discards all in-flight packets.
- Left injection latency: sampled at edge E, a packet with dest d is visible on node d `east_*` during the cycle after edge E+d, for exactly 1 cycle.
- Right injection latency: sampled at edge E, a packet with dest d is visible on node d `west_*` after edge E+(3−d).
- Throughput: one packet per lane per cycle. Back-to-back injections stay in order, one cycle apart.
- `delivered_count` is registered and lags ejection by one edge.

## Structure
- Package `noc_pkg` holds:
  - `PACKET_SIZE`, `NUM_NODES`, `ADDR_W`;
  - the field positions `DEST_LSB` and `PAYLOAD_LSB`;
  - a function that extracts dest from a packet.
- Sub-module `noc_router`:
  - parameter `NODE_ID`;
  - E and W lane registers;
  - ejection compare;
  - forward outputs to its neighbours.
- The top instantiates 4 routers with a generate loop and ties the edge injections to routers 0 and 3.
- The top holds `delivered_count`.

## Test plan
- Reset: hold `rst`=0 for 2 edges while injecting → all valids 0, all data 0, `delivered_count`=0.
- Left to far end: `left_in`=8'b0000_0011 with `left_en`=1 for one edge E, then `left_en`=Z → `east_valid`=4'b1000 and `east_data` node 3 = 8'h03 during exactly the cycle after E+3; nothing else valid; `delivered_count`=1 afterwards.
- Local eject: `left_in`=8'hA4 (dest 0) → `east_valid[0]` for 1 cycle after E with data 8'hA4. `right_in`=8'h57 (dest 3) → `west_valid[3]` after E with data 8'h57.
- Simultaneous collision: `left_in`=8'h12 (dest 2) and `right_in`=8'h3E (dest 2) at the same edge → cycle after E+2 has `east_valid[2]`=1 with 8'h12 and cycle after E+1 has `west_valid[2]`=1 with 8'h3E; `delivered_count`=2.
- Streaming: `left_en`=1 for 4 consecutive edges with dests 3,2,1,0 → node 3 ejects at E+3, node 2 at E+3, node 1 at E+3, node 0 at E+3 (all four together); `delivered_count`=4.
- Mid-flight reset: inject dest 3 at the left, then drive `rst`=0 at edge E+1 → no ejection ever occurs; the count stays 0.
